// File: rtl/mem_stage_ctrl_if.sv
// Data-memory bus between the memory-stage controller and the data memory.
`timescale 1ns/1ps
interface mem_stage_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage access controller: req/ack handshake with data memory,
// pipeline stall, store strobe/lane formatting, load alignment/extension,
// and fault reporting for misaligned, illegal and timed-out accesses.
`timescale 1ns/1ps
module mem_stage_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              Stall,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              AccessFault,
  mem_stage_ctrl_if.master  mem
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state, state_n;
  logic [TO_W-1:0] to_cnt;
  logic            op_store;
  logic [2:0]      op_f3;
  logic [1:0]      op_lo;

  logic            go, illegal, misaligned;
  logic            accept, reject, acked, expired;
  logic [3:0]      st_strb;
  logic [31:0]     st_data;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [31:0]     ld_data;

  // Classify the request presented in IDLE
  always_comb begin
    go         = MemRead | MemWrite;
    illegal    = (MemRead & MemWrite)
               | (MemRead  & !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
               | (MemWrite & !(funct3 inside {3'b000, 3'b001, 3'b010}));
    misaligned = ((funct3 == 3'b001 || funct3 == 3'b101) && addr[0])
               || (funct3 == 3'b010 && addr[1:0] != 2'b00);
  end

  // Store strobes and lane-replicated data; loads present an empty write
  always_comb begin
    st_strb = '0;
    st_data = '0;
    if (MemWrite) begin
      case (funct3[1:0])
        2'b00: begin
          st_strb = 4'b0001 << addr[1:0];
          st_data = {4{wdata[7:0]}};
        end
        2'b01: begin
          st_strb = 4'b0011 << {addr[1], 1'b0};
          st_data = {2{wdata[15:0]}};
        end
        default: begin
          st_strb = '1;
          st_data = wdata;
        end
      endcase
    end
  end

  // Load lane select and extension using the latched funct3/offset
  always_comb begin
    ld_byte = mem.mem_rdata[{op_lo, 3'b000} +: 8];
    ld_half = mem.mem_rdata[{op_lo[1], 4'b0000} +: 16];
    case (op_f3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'b0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'b0, ld_half};
      default: ld_data = mem.mem_rdata;
    endcase
  end

  // Next-state logic and combinational stall
  always_comb begin
    state_n = state;
    Stall   = 1'b0;
    accept  = 1'b0;
    reject  = 1'b0;
    acked   = 1'b0;
    expired = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          if (illegal || misaligned) begin
            reject  = 1'b1;
            state_n = DONE;
          end else begin
            accept  = 1'b1;
            Stall   = 1'b1;
            state_n = BUSY;
          end
        end
      end
      BUSY: begin
        Stall = 1'b1;
        if (mem.mem_ack) begin
          acked   = 1'b1;
          state_n = DONE;
        end else if (to_cnt == TO_LAST) begin
          expired = 1'b1;
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Bus registers, latched operation, timeout counter and result pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt        <= '0;
      op_store      <= 1'b0;
      op_f3         <= '0;
      op_lo         <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      mem.mem_wstrb <= '0;
      rdata         <= '0;
      rdata_valid   <= 1'b0;
      AccessFault   <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      AccessFault <= 1'b0;
      if (accept) begin
        mem.mem_req   <= 1'b1;
        mem.mem_we    <= MemWrite;
        mem.mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
        mem.mem_wdata <= st_data;
        mem.mem_wstrb <= st_strb;
        op_store      <= MemWrite;
        op_f3         <= funct3;
        op_lo         <= addr[1:0];
        to_cnt        <= '0;
      end
      if (reject) AccessFault <= 1'b1;
      if (acked) begin
        mem.mem_req <= 1'b0;
        mem.mem_we  <= 1'b0;
        if (!op_store) begin
          rdata       <= ld_data;
          rdata_valid <= 1'b1;
        end
      end
      if (expired) begin
        mem.mem_req <= 1'b0;
        mem.mem_we  <= 1'b0;
        AccessFault <= 1'b1;
        rdata       <= '0;
      end
      if (state == BUSY && !acked && !expired) to_cnt <= to_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed testbench for mem_stage_ctrl; the bench plays the data memory.
`timescale 1ns/1ps
module tb_mem_stage_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        Stall, rdata_valid, AccessFault;
  logic [31:0] rdata;

  int cmp_n = 0;
  int err_n = 0;

  // observation results of the last run_access
  int          obs_stall, obs_req, obs_fault, obs_valid, obs_end;
  logic        obs_we;
  logic [31:0] obs_addr, obs_wdata, obs_rdata;
  logic [3:0]  obs_strb;

  mem_stage_ctrl_if #(.ADDR_W(32)) mif ();

  mem_stage_ctrl #(.ADDR_W(32), .TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .funct3(funct3), .addr(addr), .wdata(wdata), .Stall(Stall),
    .rdata(rdata), .rdata_valid(rdata_valid), .AccessFault(AccessFault),
    .mem(mif)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic observe();
    if (Stall) obs_stall++;
    if (mif.mem_req) begin
      if (obs_req == 0) begin
        obs_we    = mif.mem_we;
        obs_addr  = mif.mem_addr;
        obs_wdata = mif.mem_wdata;
        obs_strb  = mif.mem_wstrb;
      end
      obs_req++;
    end
    if (AccessFault) obs_fault++;
    if (rdata_valid) begin
      obs_valid++;
      obs_rdata = rdata;
    end
  endtask

  // Present one instruction, answer mem_req with ack in req-cycle ack_at
  // (negative = never), then leave the stage and observe one idle cycle.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int ack_at, input logic [31:0] rword);
    obs_stall = 0; obs_req = 0; obs_fault = 0; obs_valid = 0; obs_end = -1;
    obs_we = 1'b0; obs_addr = '0; obs_wdata = '0; obs_strb = '0; obs_rdata = '0;
    tick();
    MemRead = rd; MemWrite = wr; funct3 = f3; addr = a; wdata = wd;
    for (int c = 0; c < 40 && obs_end < 0; c++) begin
      if (c > 0) tick();
      mif.mem_ack   = mif.mem_req && (obs_req == ack_at);
      mif.mem_rdata = rword;
      #1;
      observe();
      if (!Stall) obs_end = c;
    end
    mif.mem_ack = 1'b0;
    if (obs_stall == 0) begin
      tick();
      #1;
      observe();
    end
    MemRead = 1'b0; MemWrite = 1'b0;
    tick();
    #1;
    observe();
  endtask

  task automatic test_reset();
    #1;
    cmp_n++;
    if ({Stall, rdata_valid, AccessFault, mif.mem_req, mif.mem_we, mif.mem_wstrb,
         rdata, mif.mem_addr, mif.mem_wdata} !== '0) begin
      err_n++;
      $display("FAIL reset_outputs: got stall=%b req=%b we=%b strb=%b rdata=%h addr=%h wdata=%h, want all 0",
               Stall, mif.mem_req, mif.mem_we, mif.mem_wstrb, rdata, mif.mem_addr, mif.mem_wdata);
    end
  endtask

  task automatic test_lw();
    run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF);
    cmp_n++; if (obs_addr !== 32'h100) begin err_n++; $display("FAIL lw_addr: got %h want 00000100", obs_addr); end
    cmp_n++; if (obs_we !== 1'b0) begin err_n++; $display("FAIL lw_we: got %b want 0", obs_we); end
    cmp_n++; if (obs_strb !== 4'b0000) begin err_n++; $display("FAIL lw_strb: got %b want 0000", obs_strb); end
    cmp_n++; if (obs_stall !== 3) begin err_n++; $display("FAIL lw_stall: got %0d want 3", obs_stall); end
    cmp_n++; if (obs_req !== 2) begin err_n++; $display("FAIL lw_req_cycles: got %0d want 2", obs_req); end
    cmp_n++; if (obs_end !== 3) begin err_n++; $display("FAIL lw_done_cycle: got %0d want 3", obs_end); end
    cmp_n++; if (obs_valid !== 1) begin err_n++; $display("FAIL lw_valid: got %0d want 1", obs_valid); end
    cmp_n++; if (obs_rdata !== 32'hDEADBEEF) begin err_n++; $display("FAIL lw_rdata: got %h want deadbeef", obs_rdata); end
    cmp_n++; if (obs_fault !== 0) begin err_n++; $display("FAIL lw_fault: got %0d want 0", obs_fault); end
  endtask

  task automatic test_load_ext();
    run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80112233);
    cmp_n++; if (obs_rdata !== 32'hFFFFFF80) begin err_n++; $display("FAIL lb_rdata: got %h want ffffff80", obs_rdata); end
    run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h80112233);
    cmp_n++; if (obs_rdata !== 32'h00000080) begin err_n++; $display("FAIL lbu_rdata: got %h want 00000080", obs_rdata); end
    run_access(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 0, 32'h80112233);
    cmp_n++; if (obs_rdata !== 32'h00008011) begin err_n++; $display("FAIL lhu_rdata: got %h want 00008011", obs_rdata); end
    run_access(1'b1, 1'b0, 3'b001, 32'h100, 32'h0, 0, 32'h1234F0AA);
    cmp_n++; if (obs_rdata !== 32'hFFFFF0AA) begin err_n++; $display("FAIL lh_rdata: got %h want fffff0aa", obs_rdata); end
    cmp_n++; if (obs_addr !== 32'h100) begin err_n++; $display("FAIL lh_addr: got %h want 00000100", obs_addr); end
  endtask

  task automatic test_store();
    run_access(1'b0, 1'b1, 3'b000, 32'h202, 32'h000000A5, 0, 32'h0);
    cmp_n++; if (obs_strb !== 4'b0100) begin err_n++; $display("FAIL sb_strb: got %b want 0100", obs_strb); end
    cmp_n++; if (obs_wdata !== 32'hA5A5A5A5) begin err_n++; $display("FAIL sb_wdata: got %h want a5a5a5a5", obs_wdata); end
    cmp_n++; if (obs_we !== 1'b1) begin err_n++; $display("FAIL sb_we: got %b want 1", obs_we); end
    cmp_n++; if (obs_addr !== 32'h200) begin err_n++; $display("FAIL sb_addr: got %h want 00000200", obs_addr); end
    cmp_n++; if (obs_end !== 2) begin err_n++; $display("FAIL sb_done_cycle: got %0d want 2", obs_end); end
    cmp_n++; if (obs_valid !== 0) begin err_n++; $display("FAIL sb_valid: got %0d want 0", obs_valid); end
    run_access(1'b0, 1'b1, 3'b001, 32'h302, 32'h1234ABCD, 0, 32'h0);
    cmp_n++; if (obs_strb !== 4'b1100) begin err_n++; $display("FAIL sh_strb: got %b want 1100", obs_strb); end
    cmp_n++; if (obs_wdata !== 32'hABCDABCD) begin err_n++; $display("FAIL sh_wdata: got %h want abcdabcd", obs_wdata); end
    run_access(1'b0, 1'b1, 3'b010, 32'h304, 32'hCAFEF00D, 1, 32'h0);
    cmp_n++; if (obs_strb !== 4'b1111) begin err_n++; $display("FAIL sw_strb: got %b want 1111", obs_strb); end
    cmp_n++; if (obs_wdata !== 32'hCAFEF00D) begin err_n++; $display("FAIL sw_wdata: got %h want cafef00d", obs_wdata); end
  endtask

  task automatic test_faults();
    logic [31:0] tag;
    logic        vr [4];
    logic        vw [4];
    logic [2:0]  vf [4];
    logic [31:0] va [4];
    vr = '{1'b1, 1'b1, 1'b1, 1'b0};
    vw = '{1'b0, 1'b1, 1'b0, 1'b1};
    vf = '{3'b010, 3'b010, 3'b001, 3'b100};
    va = '{32'h102, 32'h100, 32'h101, 32'h100};
    for (int i = 0; i < 4; i++) begin
      tag = i;
      run_access(vr[i], vw[i], vf[i], va[i], 32'h0, 0, 32'h0);
      cmp_n++; if (obs_fault !== 1) begin err_n++; $display("FAIL fault%0d_pulse: got %0d want 1", tag, obs_fault); end
      cmp_n++; if (obs_req !== 0) begin err_n++; $display("FAIL fault%0d_req: got %0d want 0", tag, obs_req); end
      cmp_n++; if (obs_stall !== 0) begin err_n++; $display("FAIL fault%0d_stall: got %0d want 0", tag, obs_stall); end
    end
  endtask

  task automatic test_timeout();
    run_access(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 0, 32'h55AA55AA);
    cmp_n++; if (rdata !== 32'h55AA55AA) begin err_n++; $display("FAIL pre_to_rdata: got %h want 55aa55aa", rdata); end
    run_access(1'b1, 1'b0, 3'b010, 32'h404, 32'h0, -1, 32'h0);
    cmp_n++; if (obs_req !== 4) begin err_n++; $display("FAIL to_req_cycles: got %0d want 4", obs_req); end
    cmp_n++; if (obs_fault !== 1) begin err_n++; $display("FAIL to_fault: got %0d want 1", obs_fault); end
    cmp_n++; if (obs_stall !== 5) begin err_n++; $display("FAIL to_stall: got %0d want 5", obs_stall); end
    cmp_n++; if (obs_valid !== 0) begin err_n++; $display("FAIL to_valid: got %0d want 0", obs_valid); end
    cmp_n++; if (rdata !== 32'h0) begin err_n++; $display("FAIL to_rdata: got %h want 00000000", rdata); end
  endtask

  task automatic test_reset_busy();
    tick();
    MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; addr = 32'h300;
    tick();
    cmp_n++; if (mif.mem_req !== 1'b1) begin err_n++; $display("FAIL rb_req_before: got %b want 1", mif.mem_req); end
    rst = 1'b1; MemRead = 1'b0;
    tick();
    cmp_n++;
    if ({Stall, rdata_valid, AccessFault, mif.mem_req, mif.mem_we, mif.mem_wstrb,
         rdata, mif.mem_addr, mif.mem_wdata} !== '0) begin
      err_n++;
      $display("FAIL rb_outputs: got stall=%b req=%b we=%b rdata=%h addr=%h, want all 0",
               Stall, mif.mem_req, mif.mem_we, rdata, mif.mem_addr);
    end
    rst = 1'b0;
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'h12345678;
    tick();
    mif.mem_ack = 1'b0;
    cmp_n++; if (rdata_valid !== 1'b0) begin err_n++; $display("FAIL rb_late_valid: got %b want 0", rdata_valid); end
    cmp_n++; if (rdata !== 32'h0) begin err_n++; $display("FAIL rb_late_rdata: got %h want 00000000", rdata); end
    tick();
    cmp_n++; if ({rdata_valid, mif.mem_req, Stall} !== 3'b000) begin err_n++; $display("FAIL rb_idle: got %b want 000", {rdata_valid, mif.mem_req, Stall}); end
  endtask

  initial begin
    rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; funct3 = '0; addr = '0; wdata = '0;
    mif.mem_ack = 1'b0; mif.mem_rdata = '0;
    repeat (3) tick();
    test_reset();
    rst = 1'b0;
    test_lw();
    test_load_ext();
    test_store();
    test_faults();
    test_timeout();
    test_reset_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-stage access controller. It consumes the MemRead/MemWrite control bits produced by the main decoder, plus the ALU address, the store data and funct3.
- Runs a req/ack handshake with the data memory and holds the pipeline with Stall until the access completes.
- Formats store byte strobes and aligns/sign-extends load data; flags misaligned, illegal and timed-out accesses.

Parameters:
ADDR_W, 32, address width (mem_addr width).
TIMEOUT, 255, max BUSY cycles waiting for mem_ack before fault.
TO_W, 8, timeout counter width; must satisfy 2**TO_W > TIMEOUT.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
MemRead  in  1  load in memory stage (from control)
MemWrite  in  1  store in memory stage (from control)
funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal
addr  in  ADDR_W  byte address from ALU
wdata  in  32  store data (rs2)
Stall  out  1  hold pipeline
rdata  out  32  aligned, extended load result
rdata_valid  out  1  1-cycle pulse, rdata valid (loads only)
AccessFault  out  1  1-cycle pulse on misaligned/illegal/timeout
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  word address {addr[ADDR_W-1:2],2'b00}
mem_wdata  out  32  lane-replicated store data
mem_wstrb  out  4  byte enables
mem_ack  in  1  memory done, sampled only while mem_req=1
mem_rdata  in  32  read word, valid with mem_ack

Behaviour:
- Reset, synchronous, at the clk edge with rst=1:
  - state=IDLE; timeout counter=0.
  - Stall, rdata_valid, AccessFault, mem_req, mem_we = 0; mem_wstrb=0; rdata, mem_addr, mem_wdata = 0.
  - Reset overrides everything, including mid-BUSY: mem_req drops at that edge.
  - An ack arriving after reset is ignored.
- FSM states: IDLE, BUSY, DONE.
- Decision in IDLE, evaluated in priority order:
  - Request present: go = MemRead|MemWrite.
  - Illegal: MemRead&MemWrite, or funct3 illegal for the op (stores allow only 000/001/010).
  - Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0.
  - go & (illegal|misaligned): AccessFault pulses next cycle; no mem_req; Stall=0; go to DONE.
  - go & legal: latch op, funct3, addr[1:0] and formatted store data; mem_req=1, mem_we=MemWrite from next cycle; go to BUSY.
  - Stall is combinational: 1 in IDLE when go & legal, 1 throughout BUSY, 0 in DONE.
- BUSY:
  - mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb are held stable.
  - mem_ack=1 → drop mem_req next edge, go DONE; for a load, capture the formatted rdata.
  - An ack is legal in the first cycle mem_req is high.
  - Otherwise increment the counter. When counter==TIMEOUT-1 with no ack: drop mem_req, pulse AccessFault, rdata=0, go DONE.
- DONE:
  - Lasts exactly 1 cycle; Stall=0, so the instruction leaves the stage at this edge.
  - rdata_valid=1 here for a completed load only.
  - Inputs are ignored (they still show the same instruction); return to IDLE.
- Latency, legal access: request seen in cycle 0; mem_req high from cycle 1; ack in cycle k≥1; DONE in cycle k+1. Minimum 3 cycles with Stall high in cycles 0..k.
- Store formatting:
  - SB: wstrb = 4'b0001<<addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: wstrb = 4'b0011<<(2*addr[1]); wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 4'b1111; wdata passed through.
  - Loads drive mem_wstrb=0 and mem_wdata=0.
- Load formatting:
  - Byte lane select: byte = mem_rdata[8*addr[1:0] +: 8]; half = mem_rdata[16*addr[1] +: 16].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
  - rdata holds its value until the next load completes.

Test Plan:
- LW addr=0x100, ack 2 cycles after req, mem_rdata=0xDEADBEEF → mem_addr=0x100, mem_we=0, Stall high 3 cycles, rdata=0xDEADBEEF with rdata_valid in DONE.
- LB addr=0x103 and LBU addr=0x103, mem_rdata=0x80112233 → rdata=0xFFFFFF80 and 0x00000080 respectively.
- SB addr=0x202, wdata=0x000000A5, same-cycle ack → mem_wstrb=4'b0100, mem_wdata=0xA5A5A5A5, mem_we=1, total 3 cycles.
- LW addr=0x102 → AccessFault pulse, mem_req never asserts, Stall=0; same for MemRead=MemWrite=1.
- Load with ack never arriving, TIMEOUT=4 → mem_req high exactly 4 cycles, then AccessFault pulse, rdata=0, Stall drops.
- rst asserted during BUSY, then a late mem_ack → all outputs 0 on that edge, FSM in IDLE, late ack produces no rdata_valid.
